// File: rtl/branch_cmp_ctrl.sv
// D-stage branch resolution: waits for operand readiness, compares, registers outcome/target, drives redirect and stall.
// Optional performance counters are built when BRANCH_CMP_PERF_EN is defined.
module branch_cmp_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [15:0]      imm16,
    output logic             stall_d,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             br_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned OFF_W = 18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_eval;
    logic             w_need_rt;
    logic             w_ready;
    logic             w_taken;
    logic             w_rs_neg;
    logic             w_rs_zero;
    logic [WIDTH-1:0] w_offset;
    logic [WIDTH-1:0] w_target;
    logic             r_br_taken;
    logic [WIDTH-1:0] r_redirect_pc;

    assign w_need_rt = (br_type == 3'd0) || (br_type == 3'd1);
    assign w_ready   = rs_ready & (rt_ready | ~w_need_rt);
    assign w_rs_neg  = rs_val[WIDTH-1];
    assign w_rs_zero = (rs_val == '0);

    // Branch condition on signed operands; reserved encodings resolve not-taken
    always_comb begin
        w_taken = 1'b0;
        case (br_type)
            3'd0:    w_taken = (rs_val == rt_val);
            3'd1:    w_taken = (rs_val != rt_val);
            3'd2:    w_taken = w_rs_neg | w_rs_zero;
            3'd3:    w_taken = ~w_rs_neg & ~w_rs_zero;
            3'd4:    w_taken = w_rs_neg;
            3'd5:    w_taken = ~w_rs_neg;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_offset = {{(WIDTH-OFF_W){imm16[15]}}, imm16, 2'b00};
    assign w_target = pc_d + WIDTH'(4) + w_offset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Flush overrides every transition and suppresses evaluation
    always_comb begin
        w_next = r_state;
        w_eval = 1'b0;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (br_valid) begin
                        if (w_ready) begin
                            w_eval = 1'b1;
                            w_next = S_DONE;
                        end else begin
                            w_next = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_ready) begin
                        w_eval = 1'b1;
                        w_next = S_DONE;
                    end else if (!br_valid) begin
                        w_next = S_IDLE;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_br_taken    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (flush) begin
            r_br_taken    <= 1'b0;
        end else if (w_eval) begin
            r_br_taken    <= w_taken;
            r_redirect_pc <= w_target;
        end
    end

    assign stall_d        = br_valid & (r_state != S_DONE);
    assign redirect_valid = (r_state == S_DONE) & r_br_taken & ~flush;
    assign redirect_pc    = r_redirect_pc;
    assign br_taken       = r_br_taken;

`ifdef BRANCH_CMP_PERF_EN
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    // A DONE cycle killed by flush is not counted
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if ((r_state == S_DONE) && !flush) begin
            r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (r_br_taken) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;
`else
    assign branch_cnt = '0;
    assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// Bench for branch_cmp_ctrl: vector table, flush/reset sequences and randomized branches against a transaction model.
module tb_branch_cmp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        br_valid;
    logic [2:0]  br_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        br_taken;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_pc = 32'h0;
    int unsigned exp_bc = 0;
    int unsigned exp_tc = 0;

    branch_cmp_ctrl #(.WIDTH(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .br_valid(br_valid),
        .br_type(br_type), .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_d(pc_d), .imm16(imm16),
        .stall_d(stall_d), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .br_taken(br_taken),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [15:0] imm;
        int          k;
        logic        tk;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef BRANCH_CMP_PERF_EN
        chk({tag, "_branch_cnt"}, branch_cnt, exp_bc);
        chk({tag, "_taken_cnt"}, taken_cnt, exp_tc);
`else
        chk({tag, "_branch_cnt"}, branch_cnt, 32'h0);
        chk({tag, "_taken_cnt"}, taken_cnt, 32'h0);
`endif
    endtask

    // Spec-level branch rules on signed integers
    function automatic logic model_taken(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
        int signed s;
        s = $signed(rs);
        case (t)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return s <= 0;
            3'd3:    return s > 0;
            3'd4:    return s < 0;
            3'd5:    return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [15:0] imm);
        longint sum;
        sum = longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(imm));
        return sum[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Readiness as seen by the forwarding unit; rt is don't-care for single-operand types
    task automatic set_ready(input logic [2:0] t, input logic ok);
        logic need;
        need = (t < 3'd2);
        if (ok) begin
            rs_ready = 1'b1;
            rt_ready = need ? 1'b1 : 1'($urandom_range(0, 1));
        end else if (need) begin
            case ($urandom_range(0, 2))
                0:       begin rs_ready = 1'b0; rt_ready = 1'b1; end
                1:       begin rs_ready = 1'b1; rt_ready = 1'b0; end
                default: begin rs_ready = 1'b0; rt_ready = 1'b0; end
            endcase
        end else begin
            rs_ready = 1'b0;
            rt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // One branch: k not-ready cycles, one ready cycle, then the resolution cycle
    task automatic run_br(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic [15:0] imm, input int k,
                          input logic tk, input logic [31:0] tgt, input logic fl_done);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            flush = 1'b0; br_valid = 1'b1; br_type = t; pc_d = pc; imm16 = imm;
            if (i < k) begin
                rs_val = $urandom; rt_val = $urandom; set_ready(t, 1'b0);
            end else begin
                rs_val = rs; rt_val = rt; set_ready(t, 1'b1);
            end
            #1;
            chk1("hold_stall", stall_d, 1'b1);
            chk1("hold_redirect", redirect_valid, 1'b0);
        end
        @(negedge clk);
        flush = fl_done;
        #1;
        chk1("done_stall", stall_d, 1'b0);
        chk1("done_redirect", redirect_valid, tk & ~fl_done);
        chk("done_pc", redirect_pc, tgt);
        chk1("done_taken", br_taken, tk);
        last_pc = tgt;
        if (!fl_done) begin
            exp_bc++;
            if (tk) exp_tc++;
        end
    endtask

    task automatic idle(input logic chk_tk);
        @(negedge clk);
        flush = 1'b0; br_valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
        pc_d = $urandom; set_ready(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        #1;
        chk1("idle_stall", stall_d, 1'b0);
        chk1("idle_redirect", redirect_valid, 1'b0);
        chk("idle_pc", redirect_pc, last_pc);
        if (chk_tk) chk1("idle_taken_cleared", br_taken, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_1234, 32'h0000_1234, 32'h0000_3000, 16'h0004, 0, 1'b1, 32'h0000_3014};
        vecs[1]  = '{3'd1, 32'h5, 32'h5, 32'h0000_0100, 16'h0010, 0, 1'b0, 32'h0000_0144};
        vecs[2]  = '{3'd3, 32'h1, 32'h0, 32'h0000_2000, 16'hFFFE, 3, 1'b1, 32'h0000_1FFC};
        vecs[3]  = '{3'd4, 32'h8000_0000, 32'h0, 32'h0, 16'hFFFF, 0, 1'b1, 32'h0};
        vecs[4]  = '{3'd2, 32'h0, 32'h0, 32'h0000_0400, 16'h0001, 1, 1'b1, 32'h0000_0408};
        vecs[5]  = '{3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0000_0010, 16'h0002, 0, 1'b0, 32'h0000_001C};
        vecs[6]  = '{3'd2, 32'h1, 32'h0, 32'h0, 16'h0000, 2, 1'b0, 32'h0000_0004};
        vecs[7]  = '{3'd0, 32'h1, 32'h2, 32'h0000_0500, 16'h0000, 2, 1'b0, 32'h0000_0504};
        vecs[8]  = '{3'd6, 32'h0, 32'h0, 32'h0000_0040, 16'h0000, 0, 1'b0, 32'h0000_0044};
        vecs[9]  = '{3'd7, 32'h5, 32'h5, 32'h0000_0080, 16'h0001, 1, 1'b0, 32'h0000_0088};
        vecs[10] = '{3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFC, 16'h0000, 0, 1'b1, 32'h0};
        vecs[11] = '{3'd3, 32'h8000_0000, 32'h0, 32'h0000_1000, 16'h8000, 0, 1'b0, 32'hFFFE_1004};
        vecs[12] = '{3'd5, 32'h0, 32'h0, 32'h0000_0020, 16'h0003, 1, 1'b1, 32'h0000_0030};
        vecs[13] = '{3'd4, 32'h0, 32'h0, 32'h0000_0060, 16'hFFF0, 0, 1'b0, 32'h0000_0024};

        reset = 1'b0; flush = 1'b0; br_valid = 1'b0; br_type = 3'd0;
        rs_val = 32'h0; rt_val = 32'h0; rs_ready = 1'b0; rt_ready = 1'b0;
        pc_d = 32'h0; imm16 = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_stall", stall_d, 1'b0);
        chk1("rst_redirect", redirect_valid, 1'b0);
        chk("rst_pc", redirect_pc, 32'h0);
        chk1("rst_taken", br_taken, 1'b0);
        chk_cnt("rst");
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_br(vecs[i].t, vecs[i].rs, vecs[i].rt, vecs[i].pc, vecs[i].imm,
                   vecs[i].k, vecs[i].tk, vecs[i].tgt, 1'b0);
            if (i % 3 == 0) idle(1'b0);
        end
        idle(1'b0);
        chk_cnt("table");

        // Flush in WAIT: no evaluation, br_taken cleared, target untouched
        run_br(3'd0, 32'h7, 32'h7, 32'h0000_1000, 16'h0001, 0, 1'b1, 32'h0000_1008, 1'b0);
        @(negedge clk);
        br_valid = 1'b1; br_type = 3'd0; rs_val = 32'h9; rt_val = 32'h9;
        pc_d = 32'h0000_7000; imm16 = 16'h0040; set_ready(3'd0, 1'b0);
        #1;
        chk1("fw_idle_stall", stall_d, 1'b1);
        @(negedge clk);
        flush = 1'b1; set_ready(3'd0, 1'b1);
        #1;
        chk1("fw_wait_stall", stall_d, 1'b1);
        chk1("fw_wait_redirect", redirect_valid, 1'b0);
        idle(1'b1);
        run_br(3'd1, 32'h1, 32'h3, 32'h0000_0200, 16'h0002, 0, 1'b1, 32'h0000_020C, 1'b0);

        // Flush in DONE: redirect suppressed, counters untouched
        run_br(3'd5, 32'h0000_0010, 32'h0, 32'h0000_0300, 16'h0004, 1, 1'b1, 32'h0000_0314, 1'b1);
        idle(1'b1);
        chk_cnt("flush");

        // Reset (with concurrent flush) in the middle of WAIT
        run_br(3'd3, 32'h2, 32'h0, 32'h0000_0800, 16'h0001, 0, 1'b1, 32'h0000_0808, 1'b0);
        @(negedge clk);
        br_valid = 1'b1; br_type = 3'd3; rs_val = 32'h4; set_ready(3'd3, 1'b0);
        #1;
        chk1("rw_idle_stall", stall_d, 1'b1);
        @(negedge clk);
        reset = 1'b0; flush = 1'b1; set_ready(3'd3, 1'b1);
        #1;
        chk1("rw_wait_stall", stall_d, 1'b1);
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; br_valid = 1'b0;
        exp_bc = 0; exp_tc = 0; last_pc = 32'h0;
        #1;
        chk("rw_pc", redirect_pc, 32'h0);
        chk1("rw_taken", br_taken, 1'b0);
        chk1("rw_stall", stall_d, 1'b0);
        chk1("rw_redirect", redirect_valid, 1'b0);
        chk_cnt("rw");
        run_br(3'd0, 32'hA, 32'hA, 32'h0000_0000, 16'h0000, 0, 1'b1, 32'h0000_0004, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [2:0]  t;
            logic [31:0] rs;
            logic [31:0] rt;
            logic [31:0] pc;
            logic [15:0] imm;
            logic        fl;
            int          gap;
            t   = 3'($urandom_range(0, 7));
            rs  = pick();
            rt  = ($urandom_range(0, 1) == 1) ? rs : pick();
            pc  = $urandom;
            imm = 16'($urandom);
            fl  = ($urandom_range(0, 7) == 0);
            run_br(t, rs, rt, pc, imm, int'($urandom_range(0, 3)),
                   model_taken(t, rs, rt), model_target(pc, imm), fl);
            gap = int'($urandom_range(0, 2));
            if (fl && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) idle(fl && g == 0);
        end
        idle(1'b0);
        chk_cnt("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
